// File: rtl/s2p_pkg.sv
// s2p_pkg: shared definitions for the multimode serial-to-parallel converter.
//   mode_t     : run-time modulation mode encodings on the 3-bit mode input
//   state_t    : converter FSM states
//   mode2bps   : bits per symbol for a mode (0 for an unknown encoding)
//   mode_legal : mode is known and its symbol fits in max_w bits
package s2p_pkg;

    typedef enum logic [2:0] {
        MODE_BPSK  = 3'd0,
        MODE_QPSK  = 3'd1,
        MODE_8PSK  = 3'd2,
        MODE_16QAM = 3'd3,
        MODE_64QAM = 3'd4
    } mode_t;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    function automatic logic [3:0] mode2bps(input logic [2:0] mode);
        logic [3:0] bps;
        case (mode)
            MODE_BPSK:  bps = 4'd1;
            MODE_QPSK:  bps = 4'd2;
            MODE_8PSK:  bps = 4'd3;
            MODE_16QAM: bps = 4'd4;
            MODE_64QAM: bps = 4'd6;
            default:    bps = 4'd0;
        endcase
        return bps;
    endfunction

    function automatic logic mode_legal(input logic [2:0] mode, input int unsigned max_w);
        logic [3:0] bps;
        bps = mode2bps(mode);
        return (bps != 4'd0) && (32'(bps) <= max_w);
    endfunction

endpackage

// File: rtl/s2p_out_reg.sv
// s2p_out_reg: output holding register with valid/ready handshake and
// overrun detection for the serial-to-parallel converter.
//   clk, rst : clock, synchronous active-high reset
//   load     : a new symbol completed this cycle (din holds it)
//   din      : completed symbol, right-justified
//   ready    : consumer accepts when valid & ready
//   clr_ovr  : clear the sticky overrun flag (new stream starting)
//   dout     : held symbol
//   valid    : dout holds an unaccepted symbol
//   overrun  : sticky, a completed symbol was dropped
module s2p_out_reg #(
    parameter int unsigned MAX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [MAX_W-1:0] din,
    input  logic             ready,
    input  logic             clr_ovr,
    output logic [MAX_W-1:0] dout,
    output logic             valid,
    output logic             overrun
);

    always_ff @(posedge clk) begin
        if (rst) begin
            dout    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (load) begin
                // Register is free (empty or being accepted this edge): take the
                // new symbol with no bubble. Otherwise drop it, keep the held one.
                if (!valid || ready) begin
                    dout  <= din;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
            if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/s2p_multimode.sv
// s2p_multimode: run-time configurable serial-to-parallel converter.
// Collects 1/2/3/4/6 serial bits per symbol (BPSK/QPSK/8PSK/16QAM/64QAM),
// streams symbols out on a valid/ready interface while start is high.
//   CLK, RST    : clock, synchronous active-high reset
//   start       : level enable; rising edge latches mode, falling edge aborts
//   mode        : modulation mode (see s2p_pkg::mode_t)
//   serialIn    : serial bit, sampled when bitValid=1
//   bitValid    : serial bit qualifier
//   parallelOut : symbol, right-justified, unused upper bits 0
//   outValid    : parallelOut holds an unaccepted symbol
//   outReady    : consumer ready
//   busy        : collecting a stream
//   overrun     : sticky, a completed symbol was dropped
//   modeErr     : sticky, start seen with an illegal mode
//   symCount    : symbols accepted since start (only with S2P_SYMCNT_EN)
// Optional feature macro: S2P_SYMCNT_EN
module s2p_multimode
    import s2p_pkg::*;
#(
    parameter int unsigned MAX_W     = 6,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic             serialIn,
    input  logic             bitValid,
    output logic [MAX_W-1:0] parallelOut,
    output logic             outValid,
    input  logic             outReady,
    output logic             busy,
    output logic             overrun,
    output logic             modeErr
`ifdef S2P_SYMCNT_EN
    ,
    output logic [CNT_W-1:0] symCount
`endif
);

    localparam int unsigned CW = $clog2(MAX_W + 1);

    state_t           state;
    logic             start_q;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    bps;
    logic [MAX_W-1:0] shreg;

    logic             start_rise;
    logic             legal;
    logic             go;
    logic             last_bit;
    logic             sym_load;
    logic [MAX_W-1:0] sym_next;

    always_comb begin
        start_rise = start && !start_q;
        legal      = mode_legal(mode, MAX_W);
        go         = (state == IDLE) && start_rise && legal;
        last_bit   = (cnt == bps - CW'(1));
        sym_load   = (state == COLLECT) && start && bitValid && last_bit;
        // The shift register starts every symbol at zero, so the left shift
        // leaves exactly bps significant bits and the upper bits stay 0.
        if (MSB_FIRST) begin
            sym_next = {shreg[MAX_W-2:0], serialIn};
        end else begin
            sym_next = shreg | (MAX_W'(serialIn) << cnt);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            start_q <= 1'b0;
            cnt     <= '0;
            bps     <= '0;
            shreg   <= '0;
            modeErr <= 1'b0;
        end else begin
            start_q <= start;
            case (state)
                IDLE: begin
                    if (start_rise) begin
                        if (legal) begin
                            state <= COLLECT;
                            bps   <= CW'(mode2bps(mode));
                            cnt   <= '0;
                            shreg <= '0;
                        end else begin
                            modeErr <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (!start) begin
                        state <= IDLE;
                        cnt   <= '0;
                        shreg <= '0;
                    end else if (bitValid) begin
                        if (last_bit) begin
                            cnt   <= '0;
                            shreg <= '0;
                        end else begin
                            cnt   <= cnt + CW'(1);
                            shreg <= sym_next;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == COLLECT);

    s2p_out_reg #(
        .MAX_W(MAX_W)
    ) u_out (
        .clk    (CLK),
        .rst    (RST),
        .load   (sym_load),
        .din    (sym_next),
        .ready  (outReady),
        .clr_ovr(go),
        .dout   (parallelOut),
        .valid  (outValid),
        .overrun(overrun)
    );

`ifdef S2P_SYMCNT_EN
    always_ff @(posedge CLK) begin
        if (RST || go) begin
            symCount <= '0;
        end else if (outValid && outReady) begin
            symCount <= symCount + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_s2p_multimode.sv
// Testbench for s2p_multimode: two instances (MSB-first and LSB-first) share
// all inputs; a transaction-level model predicts the held symbol, flags and a
// scoreboard of symbols in presentation order.
module tb_s2p_multimode;

    localparam int unsigned MAX_W = 6;
    localparam int unsigned CNT_W = 16;
    localparam int BPS_TAB [8] = '{1, 2, 3, 4, 6, 0, 0, 0};

    logic CLK = 1'b0;
    logic RST, start, serialIn, bitValid, outReady;
    logic [2:0] mode;

    logic [MAX_W-1:0] pout_m, pout_l;
    logic valid_m, valid_l, busy_m, busy_l, ovr_m, ovr_l, merr_m, merr_l;
`ifdef S2P_SYMCNT_EN
    logic [CNT_W-1:0] cnt_m, cnt_l;
`endif

    always #5 CLK = ~CLK;

    s2p_multimode #(.MAX_W(MAX_W), .MSB_FIRST(1'b1), .CNT_W(CNT_W)) u_msb (
        .CLK(CLK), .RST(RST), .start(start), .mode(mode), .serialIn(serialIn),
        .bitValid(bitValid), .parallelOut(pout_m), .outValid(valid_m),
        .outReady(outReady), .busy(busy_m), .overrun(ovr_m), .modeErr(merr_m)
`ifdef S2P_SYMCNT_EN
        , .symCount(cnt_m)
`endif
    );

    s2p_multimode #(.MAX_W(MAX_W), .MSB_FIRST(1'b0), .CNT_W(CNT_W)) u_lsb (
        .CLK(CLK), .RST(RST), .start(start), .mode(mode), .serialIn(serialIn),
        .bitValid(bitValid), .parallelOut(pout_l), .outValid(valid_l),
        .outReady(outReady), .busy(busy_l), .overrun(ovr_l), .modeErr(merr_l)
`ifdef S2P_SYMCNT_EN
        , .symCount(cnt_l)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_busy, m_valid, m_ovr, m_merr, m_sq, m_bps, m_cnt;
    int m_val_m, m_val_l;
    int bits[$];
    int qm[$];
    int ql[$];

    function automatic int bps_of(input logic [2:0] m);
        return BPS_TAB[m];
    endfunction

    function automatic bit legal_of(input logic [2:0] m);
        return (BPS_TAB[m] != 0) && (BPS_TAB[m] <= int'(MAX_W));
    endfunction

    always @(posedge CLK) begin
        int acc, done, vm, vl;
        if (RST) begin
            m_busy = 0; m_valid = 0; m_ovr = 0; m_merr = 0; m_sq = 0;
            m_bps = 0; m_cnt = 0; m_val_m = 0; m_val_l = 0;
            bits.delete(); qm.delete(); ql.delete();
        end else begin
            acc  = (m_valid != 0) && outReady;
            done = 0;
            vm   = 0;
            vl   = 0;
            if (acc) m_cnt = (m_cnt + 1) % (1 << CNT_W);
            if (!m_busy) begin
                if (start && !m_sq) begin
                    if (legal_of(mode)) begin
                        m_busy = 1; m_bps = bps_of(mode); m_ovr = 0; m_cnt = 0;
                        bits.delete();
                    end else begin
                        m_merr = 1;
                    end
                end
            end else if (!start) begin
                m_busy = 0;
                bits.delete();
            end else if (bitValid) begin
                bits.push_back(int'(serialIn));
                if (bits.size() == m_bps) begin
                    foreach (bits[i]) begin
                        vm = vm * 2 + bits[i];
                        vl = vl + (bits[i] << i);
                    end
                    done = 1;
                    bits.delete();
                end
            end
            if (done) begin
                if (!m_valid || outReady) begin
                    m_valid = 1; m_val_m = vm; m_val_l = vl;
                    qm.push_back(vm); ql.push_back(vl);
                end else begin
                    m_ovr = 1;
                end
            end else if (acc) begin
                m_valid = 0;
            end
            m_sq = int'(start);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge CLK) begin
        chk("outValid", valid_m, m_valid);
        chk("outValid_lsb", valid_l, m_valid);
        chk("overrun", ovr_m, m_ovr);
        chk("overrun_lsb", ovr_l, m_ovr);
        chk("busy", busy_m, m_busy);
        chk("busy_lsb", busy_l, m_busy);
        chk("modeErr", merr_m, m_merr);
        chk("modeErr_lsb", merr_l, m_merr);
        chk("parallelOut", pout_m, m_val_m);
        chk("parallelOut_lsb", pout_l, m_val_l);
`ifdef S2P_SYMCNT_EN
        chk("symCount", cnt_m, m_cnt);
        chk("symCount_lsb", cnt_l, m_cnt);
`endif
        if (!RST && valid_m && outReady) begin
            if (qm.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_msb: got %0h expected none (queue empty)", pout_m);
            end else begin
                chk("sb_msb", pout_m, qm.pop_front());
            end
        end
        if (!RST && valid_l && outReady) begin
            if (ql.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_lsb: got %0h expected none (queue empty)", pout_l);
            end else begin
                chk("sb_lsb", pout_l, ql.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic s, input logic [2:0] m, input logic b,
                       input logic bv, input logic r);
        start = s; mode = m; serialIn = b; bitValid = bv; outReady = r;
        @(posedge CLK);
        #1;
    endtask

    task automatic bits_in(input logic [2:0] m, input logic [7:0] v, input int n,
                           input logic r);
        for (int i = n - 1; i >= 0; i--) cyc(1'b1, m, v[i], 1'b1, r);
    endtask

    initial begin
        RST = 1'b1; start = 1'b0; mode = 3'd0; serialIn = 1'b0;
        bitValid = 1'b0; outReady = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_pout", pout_m, 0);
        chk("reset_valid", valid_m, 0);
        chk("reset_busy", busy_m, 0);
        RST = 1'b0;

        // T1: 16QAM streaming, outReady=1
        cyc(1, 3'd3, 0, 0, 1);
        bits_in(3'd3, 8'b1100, 4, 1);
        chk("t1_sym0", pout_m, 4'b1100);
        chk("t1_sym0_lsb", pout_l, 4'b0011);
        chk("t1_valid", valid_m, 1);
        bits_in(3'd3, 8'b1001, 4, 1);
        chk("t1_sym1", pout_m, 4'b1001);
        chk("t1_ovr", ovr_m, 0);
        cyc(0, 3'd0, 0, 0, 1);

        // T2: QPSK overrun
        cyc(1, 3'd1, 0, 0, 0);
        bits_in(3'd1, 8'b10, 2, 0);
        bits_in(3'd1, 8'b11, 2, 0);
        chk("t2_ovr", ovr_m, 1);
        chk("t2_held", pout_m, 2'b10);
        chk("t2_held_lsb", pout_l, 2'b01);
        cyc(1, 3'd1, 0, 0, 1);
        chk("t2_accepted", valid_m, 0);
        cyc(0, 3'd0, 0, 0, 1);

        // T3: 64QAM with bitValid gaps
        cyc(1, 3'd4, 0, 0, 1);
        for (int i = 5; i >= 0; i--) begin
            logic [5:0] v;
            v = 6'b101101;
            cyc(1, 3'd4, v[i], 1, 1);
            cyc(1, 3'd4, ~v[i], 0, 1);
        end
        chk("t3_msb", pout_m, 6'b101101);
        chk("t3_lsb", pout_l, 6'b101101);
        bits_in(3'd4, 8'b110000, 6, 1);
        chk("t3_msb2", pout_m, 6'b110000);
        chk("t3_lsb2", pout_l, 6'b000011);
        cyc(0, 3'd0, 0, 0, 1);

        // T4: 8PSK aborted after 2 bits, restart BPSK
        cyc(1, 3'd2, 0, 0, 1);
        bits_in(3'd2, 8'b11, 2, 1);
        cyc(0, 3'd2, 1, 1, 1);
        chk("t4_busy_low", busy_m, 0);
        cyc(1, 3'd0, 0, 0, 1);
        cyc(1, 3'd0, 1, 1, 1);
        chk("t4_bpsk", pout_m, 6'b000001);
        chk("t4_valid", valid_m, 1);
        cyc(0, 3'd0, 0, 0, 1);

        // T5: illegal modes, no retry while start held
        cyc(1, 3'd6, 0, 0, 1);
        chk("t5_merr", merr_m, 1);
        chk("t5_busy", busy_m, 0);
        cyc(1, 3'd1, 1, 1, 1);
        cyc(1, 3'd1, 1, 1, 1);
        chk("t5_no_retry", busy_m, 0);
        cyc(0, 3'd5, 0, 0, 1);
        cyc(1, 3'd5, 0, 0, 1);
        cyc(0, 3'd7, 0, 0, 1);
        RST = 1'b1;
        cyc(0, 3'd0, 0, 0, 0);
        RST = 1'b0;
        chk("t5_merr_clr", merr_m, 0);

        // T6: BPSK back-to-back, then reset mid-symbol
        cyc(1, 3'd0, 0, 0, 1);
        for (int i = 0; i < 10; i++) cyc(1, 3'd0, 1'($urandom_range(0, 1)), 1, 1);
        cyc(1, 3'd0, 0, 0, 1);
`ifdef S2P_SYMCNT_EN
        chk("t6_symcount", cnt_m, 10);
`endif
        cyc(0, 3'd0, 0, 0, 0);
        cyc(1, 3'd1, 0, 0, 0);
        bits_in(3'd1, 8'b11, 2, 0);
        cyc(1, 3'd1, 1, 1, 0);
        RST = 1'b1;
        cyc(1, 3'd1, 1, 1, 0);
        RST = 1'b0;
        chk("t6_rst_pout", pout_m, 0);
        chk("t6_rst_valid", valid_m, 0);
        chk("t6_rst_busy", busy_m, 0);
        chk("t6_rst_ovr", ovr_m, 0);

        // Randomised streaming
        start = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic s;
            s = start;
            if ($urandom_range(0, 39) == 0) s = ~s;
            RST = ($urandom_range(0, 499) == 0);
            cyc(s, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7));
        end
        RST = 1'b0;
        cyc(0, 3'd0, 0, 0, 1);
        cyc(0, 3'd0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
